cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller that gates datapath updates through a one-clk cpu_ce.
// Breakpoint support is compiled in only when CPU_RUN_CTRL_BP_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             clr,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  end_pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_ce,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StStep = 3'd2,
    StBrk  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e           r_state;
  logic             r_cpu_ce;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step_meta;
  logic             r_step_sync;
  logic             r_step_prev;

  logic w_step_p;
  logic w_tick_ok;
  logic w_end_hit;
  logic w_bp_hit;

  assign w_step_p  = r_step_sync & ~r_step_prev;
  // A tick right after an issue is ignored so cpu_ce can never be high on two clks in a row.
  assign w_tick_ok = tick & ~r_cpu_ce;
  assign w_end_hit = (pc == end_pc);

`ifdef CPU_RUN_CTRL_BP_EN
  assign w_bp_hit = bp_en & (pc == bp_addr);
  assign halted   = (r_state == StBrk) | (r_state == StDone);
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{bp_en, bp_addr};
  assign w_bp_hit    = 1'b0;
  assign halted      = (r_state == StDone);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_cpu_ce    <= 1'b0;
      r_cnt       <= '0;
      r_step_meta <= 1'b0;
      r_step_sync <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_step_meta <= step_btn;
      r_step_sync <= r_step_meta;
      r_step_prev <= r_step_sync;
      r_cpu_ce    <= 1'b0;
      if (r_cpu_ce && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (run_sw) begin
            r_state <= StRun;
          end else if (w_step_p) begin
            r_state <= StStep;
          end
        end
        StRun: begin
          if (!run_sw) begin
            r_state <= StIdle;
          end else if (w_tick_ok) begin
            if (w_end_hit) begin
              r_state <= StDone;
            end else if (w_bp_hit) begin
              r_state <= StBrk;
            end else begin
              r_cpu_ce <= 1'b1;
            end
          end
        end
        StStep: begin
          if (w_tick_ok) begin
            if (w_end_hit) begin
              r_state <= StDone;
            end else begin
              r_cpu_ce <= 1'b1;
              r_state  <= StIdle;
            end
          end
        end
        StBrk: begin
          if (w_step_p) begin
            r_state <= StStep;
          end else if (!run_sw) begin
            r_state <= StIdle;
          end
        end
        StDone: begin
          if (clr) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cpu_ce     = r_cpu_ce;
  assign state_o    = r_state;
  assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl; a second instance with a 3-bit counter covers saturation.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rstn, tick, run_sw, step_btn, clr, bp_en;
  logic [31:0] pc, end_pc, bp_addr;
  logic        cpu_ce, halted;
  logic [2:0]  state_o;
  logic [15:0] retire_cnt;
  logic        ce_s, halted_s;
  logic [2:0]  state_s;
  logic [2:0]  cnt_s;

  int   total = 0;
  int   bad = 0;
  int   tick_div = 0;
  int   ph = 0;
  int   ce_seen = 0;
  logic prev_ce = 1'b0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .tick(tick), .run_sw(run_sw), .step_btn(step_btn), .clr(clr),
    .pc(pc), .end_pc(end_pc), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_ce(cpu_ce),
    .state_o(state_o), .halted(halted), .retire_cnt(retire_cnt)
  );

  cpu_run_ctrl #(.PC_W(32), .CNT_W(3)) u_dut_small (
    .clk(clk), .rstn(rstn), .tick(tick), .run_sw(run_sw), .step_btn(step_btn), .clr(clr),
    .pc(pc), .end_pc(end_pc), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_ce(ce_s),
    .state_o(state_s), .halted(halted_s), .retire_cnt(cnt_s)
  );

  // One clock: sample just after the edge, model the PC, then drive the next tick.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cpu_ce === 1'b1) begin
      total++;
      if (tick !== 1'b1 || prev_ce !== 1'b0) begin
        bad++;
        $display("FAIL ce_timing: tick=%b prev_ce=%b, required tick=1 prev_ce=0", tick, prev_ce);
      end
      ce_seen++;
      pc = pc + 32'd4;
    end
    prev_ce = cpu_ce;
    ph++;
    if (tick_div != 0) tick = ((ph % tick_div) == 0);
    else tick = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; tick = 1'b0; run_sw = 1'b0; step_btn = 1'b0; clr = 1'b0;
    bp_en = 1'b0; pc = '0; end_pc = 32'h20; bp_addr = '0;
    #12;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL rst_ce: got %b want 0", cpu_ce); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    total++; if (retire_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", retire_cnt); end
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL post_rst_idle: got %0d want 0", state_o); end
  endtask

  task automatic test_free_run();
    pc = '0; end_pc = 32'h20; bp_en = 1'b0; run_sw = 1'b1; ce_seen = 0; ph = 0; tick_div = 4;
    for (int i = 0; i < 200 && state_o !== 3'd4; i++) cyc();
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL run_done: got %0d want 4", state_o); end
    total++; if (ce_seen != 8) begin bad++; $display("FAIL run_issues: got %0d want 8", ce_seen); end
    total++; if (retire_cnt !== 16'd8) begin bad++; $display("FAIL run_cnt: got %0d want 8", retire_cnt); end
    total++; if (cnt_s !== 3'd7) begin bad++; $display("FAIL run_sat: got %0d want 7", cnt_s); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_halted: got %b want 1", halted); end
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL run_pc: got %0h want 20", pc); end
    run_sw = 1'b0;
    repeat (8) cyc();
    total++; if (state_o !== 3'd4 || ce_seen != 8) begin
      bad++; $display("FAIL done_hold: state %0d issues %0d, want 4 and 8", state_o, ce_seen);
    end
    tick_div = 0;
    clr = 1'b1; cyc(); clr = 1'b0;
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL clr_state: got %0d want 0", state_o); end
    total++; if (retire_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", retire_cnt); end
    total++; if (cnt_s !== 3'd0) begin bad++; $display("FAIL clr_sat_cnt: got %0d want 0", cnt_s); end
  endtask

  task automatic test_step();
    pc = '0; end_pc = 32'h20; run_sw = 1'b0; tick_div = 0; ce_seen = 0;
    step_btn = 1'b1; repeat (50) cyc(); step_btn = 1'b0;
    total++; if (state_o !== 3'd2 || ce_seen != 0) begin
      bad++; $display("FAIL step_wait: state %0d issues %0d, want 2 and 0", state_o, ce_seen);
    end
    repeat (3) cyc();
    step_btn = 1'b1; repeat (10) cyc(); step_btn = 1'b0; repeat (3) cyc();
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL step_repress: got %0d want 2", state_o); end
    ph = 0; tick_div = 4;
    for (int i = 0; i < 20 && ce_seen == 0; i++) cyc();
    total++; if (ce_seen != 1) begin bad++; $display("FAIL step_issue: got %0d want 1", ce_seen); end
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL step_idle: got %0d want 0", state_o); end
    repeat (20) cyc();
    total++; if (ce_seen != 1 || state_o !== 3'd0) begin
      bad++; $display("FAIL step_no_queue: issues %0d state %0d, want 1 and 0", ce_seen, state_o);
    end
    total++; if (retire_cnt !== 16'd1) begin bad++; $display("FAIL step_cnt: got %0d want 1", retire_cnt); end
    tick_div = 0;
    clr = 1'b1; cyc(); clr = 1'b0;
    total++; if (retire_cnt !== 16'd1 || state_o !== 3'd0) begin
      bad++; $display("FAIL clr_outside: cnt %0d state %0d, want 1 and 0", retire_cnt, state_o);
    end
  endtask

  task automatic test_priority();
    pc = 32'h10; end_pc = 32'h10; bp_en = 1'b1; bp_addr = 32'h10; run_sw = 1'b1;
    ce_seen = 0; ph = 0; tick_div = 4;
    for (int i = 0; i < 20 && halted !== 1'b1; i++) cyc();
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL prio_end: got %0d want 4", state_o); end
    total++; if (ce_seen != 0) begin bad++; $display("FAIL prio_noissue: got %0d want 0", ce_seen); end
    run_sw = 1'b0; tick_div = 0;
    clr = 1'b1; cyc(); clr = 1'b0;
    pc = '0; end_pc = 32'h20; bp_en = 1'b0; run_sw = 1'b1;
    cyc();
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL prio_run: got %0d want 1", state_o); end
    tick = 1'b1; run_sw = 1'b0;
    cyc();
    total++; if (state_o !== 3'd0 || cpu_ce !== 1'b0) begin
      bad++; $display("FAIL prio_runsw: state %0d ce %b, want 0 and 0", state_o, cpu_ce);
    end
    cyc();
    total++; if (ce_seen != 0) begin bad++; $display("FAIL prio_runsw_ce: got %0d want 0", ce_seen); end
  endtask

`ifdef CPU_RUN_CTRL_BP_EN
  task automatic test_breakpoint();
    pc = '0; end_pc = 32'h20; bp_en = 1'b1; bp_addr = 32'h0C; run_sw = 1'b1;
    ce_seen = 0; ph = 0; tick_div = 4;
    for (int i = 0; i < 100 && halted !== 1'b1; i++) cyc();
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL bp_state: got %0d want 3", state_o); end
    total++; if (ce_seen != 3) begin bad++; $display("FAIL bp_issues: got %0d want 3", ce_seen); end
    total++; if (pc !== 32'h0C) begin bad++; $display("FAIL bp_pc: got %0h want c", pc); end
    step_btn = 1'b1;
    for (int i = 0; i < 40 && ce_seen < 4; i++) begin
      cyc();
      if (i == 5) step_btn = 1'b0;
    end
    step_btn = 1'b0;
    total++; if (ce_seen != 4) begin bad++; $display("FAIL bp_step: got %0d want 4", ce_seen); end
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL bp_step_idle: got %0d want 0", state_o); end
    run_sw = 1'b0; tick_div = 0;
    repeat (3) cyc();
  endtask
`else
  task automatic test_macro_off();
    logic saw_brk;
    saw_brk = 1'b0;
    pc = '0; end_pc = 32'h20; bp_en = 1'b1; bp_addr = 32'h08; run_sw = 1'b1;
    ce_seen = 0; ph = 0; tick_div = 4;
    for (int i = 0; i < 200 && state_o !== 3'd4; i++) begin
      cyc();
      if (state_o === 3'd3) saw_brk = 1'b1;
    end
    total++; if (saw_brk !== 1'b0) begin bad++; $display("FAIL nobp_brk: got %b want 0", saw_brk); end
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL nobp_done: got %0d want 4", state_o); end
    total++; if (ce_seen != 8) begin bad++; $display("FAIL nobp_issues: got %0d want 8", ce_seen); end
    run_sw = 1'b0; tick_div = 0;
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask
`endif

  task automatic test_reset_midrun();
    pc = '0; end_pc = 32'h20; bp_en = 1'b0; run_sw = 1'b1; tick_div = 0;
    cyc(); cyc();
    tick = 1'b1; cyc(); cyc(); cyc();
    tick = 1'b1; cyc();
    total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", cpu_ce); end
    rstn = 1'b0;
    #1;
    total++; if (cpu_ce !== 1'b0) begin bad++; $display("FAIL mid_ce: got %b want 0", cpu_ce); end
    total++; if (retire_cnt !== 16'd0 || cnt_s !== 3'd0) begin
      bad++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", retire_cnt, cnt_s);
    end
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", state_o); end
    #3;
    rstn = 1'b1; prev_ce = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    total++; if (state_o !== 3'd1 || cpu_ce !== 1'b0) begin
      bad++; $display("FAIL rel_first: state %0d ce %b, want 1 and 0", state_o, cpu_ce);
    end
    @(posedge clk); #1;
    total++; if (cpu_ce !== 1'b1) begin bad++; $display("FAIL rel_second: got %b want 1", cpu_ce); end
    tick = 1'b0; run_sw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_priority();
`ifdef CPU_RUN_CTRL_BP_EN
    test_breakpoint();
`else
    test_macro_off();
`endif
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
